// File: rtl/button_start_ctrl.sv
// button_start_ctrl: syncs and debounces the start pushbutton, emits one start (or reject when busy) per press.
// Optional BUTTON_AUTO_REPEAT_EN: while held, each busy_in falling edge re-fires start_out.
module button_start_ctrl #(
  parameter int DEBOUNCE_CYCLES = 80000,
  parameter int CNT_W = 17,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic button_in,
  input  logic busy_in,
  output logic start_out,
  output logic pressed_out,
  output logic reject_out
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic sync_a, sync_b, p, accept, pressed_n, rep;
  assign p = sync_b ^ ACTIVE_LOW;
  // reset loads the idle pad level so reset never looks like a press edge
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) begin
      sync_a <= ACTIVE_LOW;
      sync_b <= ACTIVE_LOW;
    end else begin
      sync_a <= button_in;
      sync_b <= sync_a;
    end
`ifdef BUTTON_AUTO_REPEAT_EN
  logic busy_q;
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) busy_q <= 1'b0;
    else busy_q <= busy_in;
  assign rep = (state == PRESSED) && busy_q && !busy_in && !start_out;
`else
  assign rep = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    accept = 1'b0;
    pressed_n = pressed_out;
    unique case (state)
      RELEASED: if (p) begin
        state_n = PRESS_WAIT;
        cnt_n = '0;
      end
      PRESS_WAIT: if (!p) state_n = RELEASED;
      else if (cnt == LAST) begin
        state_n = PRESSED;
        pressed_n = 1'b1;
        accept = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      PRESSED: if (!p) begin
        state_n = RELEASE_WAIT;
        cnt_n = '0;
      end
      RELEASE_WAIT: if (p) state_n = PRESSED;
      else if (cnt == LAST) begin
        state_n = RELEASED;
        pressed_n = 1'b0;
      end else cnt_n = cnt + CNT_W'(1);
    endcase
  end
  always_ff @(posedge clock_in or posedge reset_in)
    if (reset_in) begin
      state <= RELEASED;
      cnt <= '0;
      pressed_out <= 1'b0;
      start_out <= 1'b0;
      reject_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pressed_out <= pressed_n;
      start_out <= (accept && !busy_in) || rep;
      reject_out <= accept && busy_in;
    end
endmodule
